id_hazard_ctrl: RTL and testbench

- Scoreboard and interlock controller for the ID stage's register-file read ports.
- Mirrors the destination registers of instructions in flight in EX, MEM and WB in its own shift pipeline.
- Per cycle, decides for each ID source operand whether to read the RF or forward from EX/MEM/WB, or whether to stall ID (load-use).
- Sits beside the ID stage. Its issue output replaces the hard-wired ID allow/valid coupling.

---
 rtl/id_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_id_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: tracks in-flight destinations in EX/MEM/WB,
// selects operand forwarding sources and raises the load-use stall/issue handshake.
module id_hazard_ctrl #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rj,
   input  logic             id_rj_re,
   input  logic [AW-1:0]    id_rkd,
   input  logic             id_rkd_re,
   input  logic [AW-1:0]    id_dest,
   input  logic             id_rf_we,
   input  logic             id_is_load,
   input  logic             ex_allow,
   input  logic             flush,
   output logic             id_stall,
   output logic             issue,
   output logic [1:0]       fwd_sel_rj,
   output logic [1:0]       fwd_sel_rkd,
   output logic             ex_busy,
   output logic             mem_busy,
   output logic             wb_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] dest;
      logic          ld;
   } trk_t;

   typedef enum logic [1:0] {
      SEL_RF  = 2'd0,
      SEL_EX  = 2'd1,
      SEL_MEM = 2'd2,
      SEL_WB  = 2'd3
   } fwd_sel_t;

   trk_t     e_q, m_q, w_q;
   trk_t     e_d;
   fwd_sel_t sel_rj, sel_rkd;
   logic     hz_rj, hz_rkd;
   logic     id_live;

   // Youngest producer wins, so a stale value further down the pipe is never used.
   function automatic fwd_sel_t pick_sel(input logic re, input logic [AW-1:0] addr,
                                         input trk_t e, input trk_t m, input trk_t w);
      fwd_sel_t sel;
      sel = SEL_RF;
      if (re && (addr != '0)) begin
         if (e.vld && (e.dest == addr))      sel = SEL_EX;
         else if (m.vld && (m.dest == addr)) sel = SEL_MEM;
         else if (w.vld && (w.dest == addr)) sel = SEL_WB;
      end
      return sel;
   endfunction

   // A load's data exists only from WB, so a load match in EX or MEM must wait.
   function automatic logic load_use(input logic re, input logic [AW-1:0] addr,
                                     input trk_t e, input trk_t m);
      logic act, me, mm;
      act = re && (addr != '0);
      me  = e.vld && (e.dest == addr);
      mm  = m.vld && (m.dest == addr);
      return act && ((me && e.ld) || (!me && mm && m.ld));
   endfunction

   always_comb begin
      sel_rj  = pick_sel(id_rj_re, id_rj, e_q, m_q, w_q);
      sel_rkd = pick_sel(id_rkd_re, id_rkd, e_q, m_q, w_q);
      hz_rj   = load_use(id_rj_re, id_rj, e_q, m_q);
      hz_rkd  = load_use(id_rkd_re, id_rkd, e_q, m_q);
   end

   // flush outranks the hazard: a killed instruction neither stalls nor issues.
   assign id_live     = id_valid && !flush;
   assign id_stall    = id_live && (hz_rj || hz_rkd);
   assign issue       = id_live && !id_stall && ex_allow;
   assign fwd_sel_rj  = sel_rj;
   assign fwd_sel_rkd = sel_rkd;
   assign ex_busy     = e_q.vld;
   assign mem_busy    = m_q.vld;
   assign wb_busy     = w_q.vld;

   // NOTE: every field gets a default before any conditional use, so no latch is inferred.
   always_comb begin
      e_d = '0;
      if (issue) begin
         e_d.vld  = id_rf_we && (id_dest != '0);
         e_d.dest = id_dest;
         e_d.ld   = id_is_load;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so W<=M<=E shift in parallel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else if (ex_allow) begin
         w_q <= m_q;
         m_q <= e_q;
         e_q <= e_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (id_stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: forwarding selection, load-use stall,
// flush, backpressure, async reset and counter saturation (narrow second instance).
module tb_id_hazard_ctrl;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [AW-1:0] id_rj, id_rkd, id_dest;
   logic          id_rj_re, id_rkd_re, id_rf_we, id_is_load;
   logic          ex_allow, flush;
   logic          id_stall, issue;
   logic [1:0]    fwd_sel_rj, fwd_sel_rkd;
   logic          ex_busy, mem_busy, wb_busy;
   logic [15:0]   stall_cnt;
   logic          s_id_stall, s_issue;
   logic [1:0]    s_sel_rj, s_sel_rkd;
   logic          s_ex_busy, s_mem_busy, s_wb_busy;
   logic [1:0]    s_stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_hazard_ctrl #(.AW(AW), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rj(id_rj), .id_rj_re(id_rj_re), .id_rkd(id_rkd), .id_rkd_re(id_rkd_re),
      .id_dest(id_dest), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
      .ex_allow(ex_allow), .flush(flush), .id_stall(id_stall), .issue(issue),
      .fwd_sel_rj(fwd_sel_rj), .fwd_sel_rkd(fwd_sel_rkd),
      .ex_busy(ex_busy), .mem_busy(mem_busy), .wb_busy(wb_busy), .stall_cnt(stall_cnt)
   );

   id_hazard_ctrl #(.AW(AW), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rj(id_rj), .id_rj_re(id_rj_re), .id_rkd(id_rkd), .id_rkd_re(id_rkd_re),
      .id_dest(id_dest), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
      .ex_allow(ex_allow), .flush(flush), .id_stall(s_id_stall), .issue(s_issue),
      .fwd_sel_rj(s_sel_rj), .fwd_sel_rkd(s_sel_rkd),
      .ex_busy(s_ex_busy), .mem_busy(s_mem_busy), .wb_busy(s_wb_busy), .stall_cnt(s_stall_cnt)
   );

   task automatic idle();
      id_valid = 0; id_rj = 0; id_rj_re = 0; id_rkd = 0; id_rkd_re = 0;
      id_dest = 0; id_rf_we = 0; id_is_load = 0; flush = 0; ex_allow = 1;
   endtask

   task automatic set_instr(input logic [AW-1:0] rj, input logic rj_re,
                            input logic [AW-1:0] rkd, input logic rkd_re,
                            input logic [AW-1:0] dest, input logic we, input logic ld);
      id_valid = 1; id_rj = rj; id_rj_re = rj_re; id_rkd = rkd; id_rkd_re = rkd_re;
      id_dest = dest; id_rf_we = we; id_is_load = ld;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      #3;
      total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", id_stall); end
      total++; if (issue !== 1'b0) begin bad++; $display("FAIL reset_issue: got %b want 0", issue); end
      total++; if ({fwd_sel_rj, fwd_sel_rkd} !== 4'b0) begin bad++; $display("FAIL reset_sel: got %b want 0000", {fwd_sel_rj, fwd_sel_rkd}); end
      total++; if ({ex_busy, mem_busy, wb_busy} !== 3'b0) begin bad++; $display("FAIL reset_busy: got %b want 000", {ex_busy, mem_busy, wb_busy}); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
      set_instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
      #1;
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL reset_valid_issue: got %b want 1", issue); end
      do_reset();
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_instr(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);   // add r5,r1,r2
      #2;
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL b2b_first_issue: got %b want 1", issue); end
      tick();
      set_instr(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);   // add r6,r5,r5
      #2;
      total++; if (fwd_sel_rj !== 2'd1) begin bad++; $display("FAIL b2b_sel_rj: got %0d want 1", fwd_sel_rj); end
      total++; if (fwd_sel_rkd !== 2'd1) begin bad++; $display("FAIL b2b_sel_rkd: got %0d want 1", fwd_sel_rkd); end
      total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall: got %b want 0", id_stall); end
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL b2b_issue: got %b want 1", issue); end
      tick();
      set_instr(5'd5, 1, 5'd7, 0, 5'd10, 1, 0);  // reads r5, rkd unused
      #2;
      total++; if (fwd_sel_rj !== 2'd2) begin bad++; $display("FAIL b2b_third_sel: got %0d want 2", fwd_sel_rj); end
      total++; if (fwd_sel_rkd !== 2'd0) begin bad++; $display("FAIL b2b_inactive_sel: got %0d want 0", fwd_sel_rkd); end
      total++; if ({ex_busy, mem_busy, wb_busy} !== 3'b110) begin bad++; $display("FAIL b2b_busy: got %b want 110", {ex_busy, mem_busy, wb_busy}); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_instr(5'd1, 1, 5'd0, 0, 5'd7, 1, 1);   // ld r7
      tick();
      set_instr(5'd7, 1, 5'd0, 1, 5'd8, 1, 0);   // add r8,r7,r0
      for (int c = 0; c < 2; c++) begin
         #2;
         total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL lu_stall_c%0d: got %b want 1", c, id_stall); end
         total++; if (issue !== 1'b0) begin bad++; $display("FAIL lu_issue_c%0d: got %b want 0", c, issue); end
         tick();
      end
      #2;
      total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL lu_release_stall: got %b want 0", id_stall); end
      total++; if (fwd_sel_rj !== 2'd3) begin bad++; $display("FAIL lu_sel_rj: got %0d want 3", fwd_sel_rj); end
      total++; if (fwd_sel_rkd !== 2'd0) begin bad++; $display("FAIL lu_sel_r0: got %0d want 0", fwd_sel_rkd); end
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL lu_issue: got %b want 1", issue); end
      total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL lu_cnt: got %0d want 2", stall_cnt); end
   endtask

   task automatic test_priority();
      do_reset();
      set_instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);   // add r3 (older)
      tick();
      set_instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);   // add r3 (younger)
      tick();
      idle();
      tick();
      set_instr(5'd3, 1, 5'd3, 1, 5'd0, 1, 1);   // reads r3 twice, load into r0
      #2;
      total++; if (fwd_sel_rj !== 2'd2) begin bad++; $display("FAIL prio_sel_rj: got %0d want 2", fwd_sel_rj); end
      total++; if (fwd_sel_rkd !== 2'd2) begin bad++; $display("FAIL prio_sel_rkd: got %0d want 2", fwd_sel_rkd); end
      total++; if ({ex_busy, mem_busy, wb_busy} !== 3'b011) begin bad++; $display("FAIL prio_busy: got %b want 011", {ex_busy, mem_busy, wb_busy}); end
      tick();
      set_instr(5'd0, 1, 5'd0, 1, 5'd9, 1, 0);   // reads r0
      #2;
      total++; if ({fwd_sel_rj, fwd_sel_rkd} !== 4'b0) begin bad++; $display("FAIL r0_sel: got %b want 0000", {fwd_sel_rj, fwd_sel_rkd}); end
      total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL r0_stall: got %b want 0", id_stall); end
      total++; if (ex_busy !== 1'b0) begin bad++; $display("FAIL r0_ex_busy: got %b want 0", ex_busy); end
   endtask

   task automatic test_flush_hazard();
      do_reset();
      set_instr(5'd1, 1, 5'd0, 0, 5'd9, 1, 1);   // ld r9
      tick();
      set_instr(5'd9, 1, 5'd0, 0, 5'd12, 1, 0);
      flush = 1;
      #2;
      total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", id_stall); end
      total++; if (issue !== 1'b0) begin bad++; $display("FAIL flush_issue: got %b want 0", issue); end
      tick();
      idle();
      #2;
      total++; if ({ex_busy, mem_busy} !== 2'b01) begin bad++; $display("FAIL flush_bubble: got %b want 01", {ex_busy, mem_busy}); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      do_reset();
      set_instr(5'd1, 1, 5'd0, 0, 5'd4, 1, 1);   // ld r4
      tick();
      idle();
      tick();
      set_instr(5'd2, 1, 5'd4, 1, 5'd13, 1, 0);  // dependent on r4 via rkd
      ex_allow = 0;
      for (int c = 0; c < 3; c++) begin
         #2;
         total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL bp_stall_c%0d: got %b want 1", c, id_stall); end
         total++; if ({ex_busy, mem_busy, wb_busy} !== 3'b010) begin bad++; $display("FAIL bp_hold_c%0d: got %b want 010", c, {ex_busy, mem_busy, wb_busy}); end
         tick();
      end
      #2;
      total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL bp_cnt3: got %0d want 3", stall_cnt); end
      ex_allow = 1;
      #1;
      total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL bp_resume_stall: got %b want 1", id_stall); end
      tick();
      #2;
      total++; if (wb_busy !== 1'b1) begin bad++; $display("FAIL bp_wb: got %b want 1", wb_busy); end
      total++; if (fwd_sel_rkd !== 2'd3) begin bad++; $display("FAIL bp_sel_rkd: got %0d want 3", fwd_sel_rkd); end
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL bp_issue: got %b want 1", issue); end
      total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL bp_cnt4: got %0d want 4", stall_cnt); end
      total++; if (s_stall_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt: got %0d want 3", s_stall_cnt); end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_instr(5'd1, 1, 5'd0, 0, 5'd11, 1, 1);  // ld r11
      tick();
      set_instr(5'd11, 1, 5'd0, 0, 5'd14, 1, 0);
      tick();
      #2;
      total++; if ((id_stall !== 1'b1) || (stall_cnt !== 16'd1)) begin bad++; $display("FAIL ar_pre: got stall=%b cnt=%0d want stall=1 cnt=1", id_stall, stall_cnt); end
      reset = 1;
      #1;
      total++; if ({ex_busy, mem_busy, wb_busy} !== 3'b000) begin bad++; $display("FAIL ar_busy: got %b want 000", {ex_busy, mem_busy, wb_busy}); end
      total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL ar_stall: got %b want 0", id_stall); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", stall_cnt); end
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL ar_issue: got %b want 1", issue); end
      reset = 0;
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      test_reset();
      test_back_to_back();
      test_load_use();
      test_priority();
      test_flush_hazard();
      test_backpressure();
      test_async_reset();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
